// File: rtl/divider_if.sv
// Controller-side bundle for the sequential divider: operands, start/clear
// handshake and results.
interface divider_if;
    localparam int unsigned W = 32;

    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         op_start;
    logic         op_clear;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;
    logic         op_done;

    modport master (
        output dividend, divisor, op_start, op_clear,
        input  quotient, remainder, div_zero, op_done
    );

    modport slave (
        input  dividend, divisor, op_start, op_clear,
        output quotient, remainder, div_zero, op_done
    );
endinterface

// File: rtl/divider.sv
// Sequential unsigned 32-bit restoring divider, one quotient bit per clock.
// Shares the op_start / op_clear / op_done handshake with the shift-add multiplier.
module divider (
    input  logic      clk,
    input  logic      reset_n,
    divider_if.slave  bus
);
    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = $clog2(W);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        EXEC   = 2'b01,
        DONE   = 2'b10,
        UNUSED = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     q_q, q_d;
    logic [W-1:0]     r_q, r_d;
    logic [W-1:0]     d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dz_q, dz_d;

    // Partial remainder shifted left with the next dividend bit, and trial subtraction.
    // The stored remainder never exceeds 32 bits, so bit 32 of the working value lives only here.
    logic [W:0]       rem_shift;
    logic [W:0]       trial;

    always_comb begin
        rem_shift = {r_q, q_q[W-1]};
        trial     = rem_shift - {1'b0, d_q};
    end

    // Next-state and datapath update; op_clear overrides every other request.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;

        if (bus.op_clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.op_start) begin
                        state_d = EXEC;
                        q_d     = bus.dividend;
                        d_d     = bus.divisor;
                        r_d     = '0;
                        cnt_d   = '0;
                        dz_d    = (bus.divisor == '0);
                    end
                end
                EXEC: begin
                    if (!trial[W]) begin
                        r_d = trial[W-1:0];
                        q_d = {q_q[W-2:0], 1'b1};
                    end else begin
                        r_d = rem_shift[W-1:0];
                        q_d = {q_q[W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(W-1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end

    // Results are exposed only in DONE so an aborted run never leaks a partial value.
    assign bus.op_done   = (state_q == DONE);
    assign bus.quotient  = (state_q == DONE) ? q_q  : '0;
    assign bus.remainder = (state_q == DONE) ? r_q  : '0;
    assign bus.div_zero  = (state_q == DONE) ? dz_q : 1'b0;
endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes expected results, a negedge
// monitor pops and checks them whenever op_done is presented.
module tb_divider;
    logic clk;
    logic reset_n;
    int   cyc;
    int   errors;
    int   checks;

    divider_if bus ();

    divider dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          start;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic have_cur;
    logic done_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pop on op_done rise, then hold-check every cycle while DONE persists.
    always @(negedge clk) begin
        if (bus.op_done) begin
            if (!done_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_op_done", 64'd1, 64'd0);
                    have_cur = 1'b0;
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                    check("latency", 64'(cyc - cur.start), 64'd32);
                    if (cur.b != 32'd0) begin
                        check("invariant_sum", 64'(bus.quotient) * 64'(cur.b) + 64'(bus.remainder), 64'(cur.a));
                        check("invariant_rem_lt_div", 64'(bus.remainder < cur.b), 64'd1);
                    end
                end
            end
            if (have_cur) begin
                check("quotient", 64'(bus.quotient), 64'(cur.q));
                check("remainder", 64'(bus.remainder), 64'(cur.r));
                check("div_zero", 64'(bus.div_zero), 64'(cur.dz));
            end
        end else begin
            have_cur = 1'b0;
        end
        done_prev = bus.op_done;
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] q, input logic [31:0] r,
                            input logic dz, input bit expect_result);
        exp_t e;
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.op_start = 1'b1;
        if (expect_result) begin
            e.a = a; e.b = b; e.q = q; e.r = r; e.dz = dz; e.start = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.op_start = 1'b0;
    endtask

    // Waits for op_done with a bound; scrambles operand inputs meanwhile.
    task automatic wait_done(input bit scramble);
        int n = 0;
        while (!bus.op_done && n < 40) begin
            if (scramble) begin
                bus.dividend = $urandom;
                bus.divisor  = $urandom;
            end
            @(negedge clk);
            n++;
        end
        if (!bus.op_done) check("op_done_timeout", 64'd0, 64'd1);
    endtask

    task automatic clear_op();
        @(negedge clk);
        bus.op_clear = 1'b1;
        @(negedge clk);
        bus.op_clear = 1'b0;
        check("clear_op_done", 64'(bus.op_done), 64'd0);
        check("clear_quotient", 64'(bus.quotient), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_op_done"}, 64'(bus.op_done), 64'd0);
        check({tag, "_quotient"}, 64'(bus.quotient), 64'd0);
        check({tag, "_remainder"}, 64'(bus.remainder), 64'd0);
        check({tag, "_div_zero"}, 64'(bus.div_zero), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        cyc          = 0;
        errors       = 0;
        checks       = 0;
        have_cur     = 1'b0;
        done_prev    = 1'b0;
        reset_n      = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        bus.op_start = 1'b0;
        bus.op_clear = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;

        // Basic operation, results held for 10 cycles before clear.
        start_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
        wait_done(1'b0);
        repeat (10) @(negedge clk);
        clear_op();

        // Extremes.
        start_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
        wait_done(1'b0);
        clear_op();
        start_op(32'd5, 32'hFFFF_FFFF, 32'd0, 32'd5, 1'b0, 1'b1);
        wait_done(1'b0);
        clear_op();
        start_op(32'd0, 32'd9, 32'd0, 32'd0, 1'b0, 1'b1);
        wait_done(1'b0);
        clear_op();

        // Divide by zero.
        start_op(32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b1);
        wait_done(1'b0);
        clear_op();

        // Abort during EXEC: no result may appear.
        start_op(32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        clear_op();
        check_outputs_zero("abort");
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(bus.op_done), 64'd0);

        // op_clear and op_start together: stays in IDLE.
        @(negedge clk);
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
        bus.op_start = 1'b1;
        bus.op_clear = 1'b1;
        @(negedge clk);
        bus.op_start = 1'b0;
        bus.op_clear = 1'b0;
        repeat (40) @(negedge clk);
        check("clear_start_no_done", 64'(bus.op_done), 64'd0);

        // op_start in DONE is ignored; monitor keeps checking held results.
        start_op(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b1);
        wait_done(1'b0);
        bus.dividend = 32'd77;
        bus.divisor  = 32'd0;
        bus.op_start = 1'b1;
        @(negedge clk);
        bus.op_start = 1'b0;
        repeat (5) @(negedge clk);
        clear_op();

        // Asynchronous reset mid-operation.
        start_op(32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (19) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        start_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
        wait_done(1'b0);
        clear_op();

        // Random operands with nonzero divisor; inputs scrambled during EXEC.
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            if (b == 32'd0) b = 32'd1;
            start_op(a, b, a / b, a % b, 1'b0, 1'b1);
            wait_done(1'b1);
            clear_op();
        end

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
